// File: rtl/tictactoe_controller_if.sv
// Board-occupancy inputs, tick enable and result outputs of the tic-tac-toe controller.
// The environment drives through master; the controller consumes through slave.
interface tictactoe_controller_if;
  logic       en;
  logic [7:0] b1;
  logic [7:0] b2;
  logic [7:0] b3;
  logic [7:0] r1;
  logic [7:0] r2;
  logic [7:0] r3;
  logic [1:0] winner;
  logic       tick;

  modport master (
    output en, b1, b2, b3, r1, r2, r3,
    input  winner, tick
  );

  modport slave (
    input  en, b1, b2, b3, r1, r2, r3,
    output winner, tick
  );
endinterface

// File: rtl/tictactoe_controller.sv
// Tic-tac-toe referee: latches a sticky game result from the red/blue occupancy bytes
// and runs an independent free-running scan-tick generator.
module tictactoe_controller #(
  parameter logic [25:0] TICK_LIMIT = 26'd500000
) (
  input  logic                   clk,
  input  logic                   reset,
  tictactoe_controller_if.slave  bus
);

  localparam logic [25:0] CNT_LAST = TICK_LIMIT - 26'd1;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_RED  = 2'b01;
  localparam logic [1:0] RES_BLUE = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // Only even bits 0/2/4 of each row byte carry cells; index = 3*row + column.
  function automatic logic [8:0] board_cells(input logic [7:0] row1,
                                             input logic [7:0] row2,
                                             input logic [7:0] row3);
    return {row3[4], row3[2], row3[0],
            row2[4], row2[2], row2[0],
            row1[4], row1[2], row1[0]};
  endfunction

  function automatic logic has_line(input logic [8:0] c);
    logic rows, cols, diags;
    rows  = (&c[2:0]) | (&c[5:3]) | (&c[8:6]);
    cols  = (c[0] & c[3] & c[6]) | (c[1] & c[4] & c[7]) | (c[2] & c[5] & c[8]);
    diags = (c[0] & c[4] & c[8]) | (c[2] & c[4] & c[6]);
    return rows | cols | diags;
  endfunction

  logic [8:0]  red_cells;
  logic [8:0]  blue_cells;
  logic        red_line;
  logic        blue_line;
  logic        board_full;
  logic [1:0]  next_result;

  logic [1:0]  winner_q, winner_d;
  logic [25:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;

  logic        unused_bits;
  assign unused_bits = ^{bus.r1[7:5], bus.r1[3], bus.r1[1],
                         bus.r2[7:5], bus.r2[3], bus.r2[1],
                         bus.r3[7:5], bus.r3[3], bus.r3[1],
                         bus.b1[7:5], bus.b1[3], bus.b1[1],
                         bus.b2[7:5], bus.b2[3], bus.b2[1],
                         bus.b3[7:5], bus.b3[3], bus.b3[1]};

  always_comb begin
    red_cells  = board_cells(bus.r1, bus.r2, bus.r3);
    blue_cells = board_cells(bus.b1, bus.b2, bus.b3);
    red_line   = has_line(red_cells);
    blue_line  = has_line(blue_cells);
    board_full = &(red_cells | blue_cells);

    next_result = RES_NONE;
    if (red_line && blue_line) next_result = RES_DRAW;
    else if (red_line)         next_result = RES_RED;
    else if (blue_line)        next_result = RES_BLUE;
    else if (board_full)       next_result = RES_DRAW;
  end

  // Result is sticky: once decided, later board changes are ignored until reset.
  always_comb begin
    winner_d = winner_q;
    if (winner_q == RES_NONE) winner_d = next_result;
  end

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (bus.en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = 26'd0;
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + 26'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner_q <= RES_NONE;
      cnt_q    <= 26'd0;
      tick_q   <= 1'b0;
    end else begin
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.winner = winner_q;
  assign bus.tick   = tick_q;

endmodule

// File: tb/tb_tictactoe_controller.sv
// Scoreboard bench for tictactoe_controller: a board-level reference model queues the
// expected {winner,tick} per edge and a monitor pops and compares after each edge.
module tb_tictactoe_controller;

  localparam int TL = 4;

  logic clk;
  logic reset;

  tictactoe_controller_if ifc ();

  tictactoe_controller #(.TICK_LIMIT(26'(TL))) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] exp_q[$];

  logic [1:0] m_win;
  int         m_cnt;
  logic       m_tick;

  // Reference: cells as a 3x3 grid, lines enumerated directly.
  function automatic bit ref_line(input logic [2:0][7:0] rows);
    bit occ[3][3];
    bit found;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        occ[r][c] = rows[r][2*c];
    found = 0;
    for (int k = 0; k < 3; k++) begin
      if (occ[k][0] && occ[k][1] && occ[k][2]) found = 1;
      if (occ[0][k] && occ[1][k] && occ[2][k]) found = 1;
    end
    if (occ[0][0] && occ[1][1] && occ[2][2]) found = 1;
    if (occ[0][2] && occ[1][1] && occ[2][0]) found = 1;
    return found;
  endfunction

  function automatic logic [1:0] ref_result(input logic [2:0][7:0] rr,
                                            input logic [2:0][7:0] bb);
    bit rl, bl;
    int filled;
    rl = ref_line(rr);
    bl = ref_line(bb);
    filled = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (rr[r][2*c] || bb[r][2*c]) filled++;
    if (rl && bl)     return 2'b11;
    if (rl)           return 2'b01;
    if (bl)           return 2'b10;
    if (filled == 9)  return 2'b11;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Called at a point before the next rising edge; covers exactly one edge.
  task automatic drive(input logic [7:0] vr1, input logic [7:0] vr2, input logic [7:0] vr3,
                       input logic [7:0] vb1, input logic [7:0] vb2, input logic [7:0] vb3,
                       input logic ven);
    ifc.r1 = vr1; ifc.r2 = vr2; ifc.r3 = vr3;
    ifc.b1 = vb1; ifc.b2 = vb2; ifc.b3 = vb3;
    ifc.en = ven;
    if (m_win == 2'b00) m_win = ref_result({vr3, vr2, vr1}, {vb3, vb2, vb1});
    m_tick = 1'b0;
    if (ven) begin
      if (m_cnt == TL - 1) begin
        m_cnt  = 0;
        m_tick = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    exp_q.push_back({m_win, m_tick});
    @(negedge clk);
  endtask

  // Asynchronous pulse between edges; caller then drives before the coming edge.
  task automatic reset_pulse();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_winner", 32'(ifc.winner), 32'd0);
    check("async_rst_tick",   32'(ifc.tick),   32'd0);
    reset = 1'b0;
    m_win  = 2'b00;
    m_cnt  = 0;
    m_tick = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      check("winner", 32'(ifc.winner), 32'(e[2:1]));
      check("tick",   32'(ifc.tick),   32'(e[0]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb [6];
    ifc.en = 1'b0;
    ifc.r1 = '0; ifc.r2 = '0; ifc.r3 = '0;
    ifc.b1 = '0; ifc.b2 = '0; ifc.b3 = '0;
    m_win = 2'b00; m_cnt = 0; m_tick = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_winner", 32'(ifc.winner), 32'd0);
    check("reset_tick",   32'(ifc.tick),   32'd0);
    reset = 1'b0;

    // Empty board stays undecided.
    repeat (10) drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    // Red top row, then a blue line must not override the sticky result.
    drive(8'h15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (3) drive(8'h15, 8'h00, 8'h00, 8'h00, 8'h15, 8'h15, 1'b0);

    // Blue main diagonal, then anti-diagonal from reset.
    reset_pulse();
    repeat (2) drive(8'h00, 8'h00, 8'h00, 8'h01, 8'h04, 8'h10, 1'b0);
    reset_pulse();
    repeat (2) drive(8'h00, 8'h00, 8'h00, 8'h10, 8'h04, 8'h01, 1'b0);

    // Full board with no line is a draw; ignored bits alone are nothing.
    reset_pulse();
    repeat (2) drive(8'h05, 8'h10, 8'h05, 8'h10, 8'h05, 8'h10, 1'b0);
    reset_pulse();
    repeat (3) drive(8'hEA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    // Both colours with a line at once.
    reset_pulse();
    repeat (2) drive(8'h15, 8'h00, 8'h00, 8'h00, 8'h15, 8'h00, 1'b0);

    // Tick period with en held, then a 3-cycle en gap.
    reset_pulse();
    for (int c = 1; c <= 20; c++)
      drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, (c >= 6 && c <= 8) ? 1'b0 : 1'b1);

    // Red wins, async reset mid-game and mid-count, re-latch on the next edge.
    reset_pulse();
    repeat (3) drive(8'h15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    reset_pulse();
    repeat (3) drive(8'h15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

    // Randomised boards and enable, with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 6; k++)
        rb[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) reset_pulse();
      drive(rb[0], rb[1], rb[2], rb[3], rb[4], rb[5], 1'($urandom_range(0, 3) != 0));
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tictactoe_controller.md
TICTACTOE_CONTROLLER -- requirements
Module: tictactoe_controller

Interface
REQ-001 Parameter TICK_LIMIT, default 500000 (26-bit), SHALL set the scan-tick period in clock cycles; legal range 2..2^26-1.
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 en  input  1  SHALL enable the tick counter.
REQ-005 b1, b2, b3  input  8 each  SHALL carry blue-player occupancy for board rows 1, 2, 3.
REQ-006 r1, r2, r3  input  8 each  SHALL carry red-player occupancy for board rows 1, 2, 3.
REQ-007 winner  output  2  SHALL report game result: 00 none, 01 red wins, 10 blue wins, 11 draw.
REQ-008 tick  output  1  SHALL be a one-cycle scan-rate strobe.

Function
REQ-009 Cell (row n, column c), c=0..2, SHALL be occupied by a colour when bit 2c of that colour's row byte is 1; bits 1, 3, 5, 6, 7 SHALL be ignored.
REQ-010 A colour SHALL have a line when it occupies all three cells of any of 8 lines: 3 rows, 3 columns, main diagonal (1,0)(2,1)(3,2), anti-diagonal (1,2)(2,1)(3,0).
REQ-011 Next-result SHALL be: red line only -> 01; blue line only -> 10; both colours have a line -> 11; neither, with all 9 cells occupied by at least one colour -> 11; otherwise 00.
REQ-012 A cell set in both colours SHALL count as occupied for each colour independently.
REQ-013 winner SHALL be registered: latency one rising clk edge from input change to output.
REQ-014 winner SHALL be sticky: once nonzero it SHALL hold its value regardless of later inputs until reset.
REQ-015 While winner is 00 it SHALL load the next-result every cycle.
REQ-016 Tick counter SHALL be 26 bits, counting 0..TICK_LIMIT-1 while en=1, wrapping to 0 after TICK_LIMIT-1.
REQ-017 tick SHALL be registered and high for exactly the one cycle following the edge on which the counter wraps; period TICK_LIMIT cycles with en held high.
REQ-018 With en=0 the counter SHALL hold its value and tick SHALL be 0 on the next cycle.
REQ-019 Winner logic and tick counter SHALL be independent; en SHALL not affect winner.

Reset
REQ-020 Asserting reset SHALL immediately force winner=00, tick=0, counter=0, independent of clk.
REQ-021 On reset release, winner SHALL evaluate inputs at the first rising edge; counter SHALL start from 0.
REQ-022 Reset asserted mid-game or mid-count SHALL discard the latched result and count with no residual tick.

Verification
REQ-023 All inputs 0, run 10 cycles -> winner=00 throughout.
REQ-024 r1=8'h15, others 0 -> winner=01 one edge later; then set b2=b3=8'h15 -> winner stays 01.
REQ-025 b1=8'h01, b2=8'h04, b3=8'h10 (main diagonal) -> winner=10; b1=8'h10, b2=8'h04, b3=8'h01 (anti-diagonal) from reset -> winner=10.
REQ-026 r1=8'h05, b1=8'h10, r2=8'h10, b2=8'h05, r3=8'h05, b3=8'h10 (full board, no line) -> winner=11; r1=8'hEA (only ignored bits) -> winner=00.
REQ-027 TICK_LIMIT=4, en=1 after reset -> tick high on cycles 4, 8, 12; drop en at cycle 6 for 3 cycles -> next tick delayed by 3 cycles to cycle 11.
REQ-028 winner=01 latched, pulse reset asynchronously between edges -> winner=00 before next edge, re-latches 01 on the next edge if r1 still 8'h15.
